core_issue_control: RTL

Sequencing controller between fetch/decode and execute in the ARM core.
- Consumes core_decode outputs for the instruction at decode.
- Owns the architectural PC, as a word address.
- Issues instructions to execute with a valid/ready handshake.
- Tracks pending register writebacks in a 16-entry scoreboard.
- Handles branch redirects, writes to R15 and undefined-instruction traps.

---
 rtl/core_issue_control.sv | 118 +++++++++++
 1 files changed

// File: rtl/core_issue_control.sv
// Issue sequencer between decode and execute: owns the word-address PC, tracks
// pending register writebacks, and handles branch, R15-write and undefined-trap redirects.
module core_issue_control #(
  parameter logic [29:0] RESET_PC     = 30'h0,
  parameter logic [29:0] UNDEF_VECTOR = 30'h1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [29:0] pc,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic        dec_execute,
  input  logic        dec_undefined,
  input  logic        dec_writeback,
  input  logic        dec_branch,
  input  logic [29:0] dec_branch_offset,
  input  logic [3:0]  dec_rd,
  output logic        issue_valid,
  input  logic        issue_ready,
  input  logic        wb_done,
  input  logic [3:0]  wb_rd,
  input  logic [29:0] wb_pc,
  output logic        flush,
  output logic        exc_undef
);

  typedef enum logic [2:0] {RUN, HAZARD, DRAIN, PCWAIT, REDIRECT} state_t;

  state_t      state;
  logic [15:0] sb;
  logic        trap;
  logic        fire;
  logic        waw;
  logic [15:0] sb_set;
  logic [15:0] sb_clr;
  logic [15:0] sb_next;

  assign waw = dec_writeback && sb[dec_rd];

  always_comb begin
    issue_valid = 1'b0;
    fetch_ready = 1'b0;
    if (state == RUN && fetch_valid) begin
      if (dec_undefined || !dec_execute) begin
        fetch_ready = 1'b1;
      end else if (!waw) begin
        issue_valid = 1'b1;
        fetch_ready = issue_ready;
      end
    end
  end

  assign fire    = issue_valid && issue_ready;
  assign sb_set  = (fire && dec_writeback) ? (16'h0001 << dec_rd) : 16'h0000;
  assign sb_clr  = wb_done ? (16'h0001 << wb_rd) : 16'h0000;
  // set applied after clear so a same-cycle issue keeps the bit pending
  assign sb_next = (sb & ~sb_clr) | sb_set;

  assign flush     = (state == REDIRECT);
  assign exc_undef = (state == REDIRECT) && trap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC;
      sb    <= 16'h0000;
      state <= RUN;
      trap  <= 1'b0;
    end else begin
      sb <= sb_next;
      case (state)
        RUN: begin
          if (fetch_valid) begin
            if (dec_undefined) begin
              state <= DRAIN;
            end else if (!dec_execute) begin
              pc <= pc + 30'd1;
            end else if (waw) begin
              state <= HAZARD;
            end else if (fire) begin
              if (dec_branch) begin
                // PC+8 view: branch target is relative to pc+2 words
                pc    <= pc + 30'd2 + dec_branch_offset;
                state <= REDIRECT;
              end else if (dec_writeback && dec_rd == 4'd15) begin
                state <= PCWAIT;
              end else begin
                pc <= pc + 30'd1;
              end
            end
          end
        end
        HAZARD: begin
          // look through this cycle's writeback so issue follows one cycle later
          if (!sb_next[dec_rd]) state <= RUN;
        end
        DRAIN: begin
          if (sb == 16'h0000) begin
            pc    <= UNDEF_VECTOR;
            trap  <= 1'b1;
            state <= REDIRECT;
          end
        end
        PCWAIT: begin
          if (wb_done && wb_rd == 4'd15) begin
            pc    <= wb_pc;
            state <= REDIRECT;
          end
        end
        REDIRECT: begin
          trap  <= 1'b0;
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
